// File: rtl/optmult.sv
// optmult: fully pipelined M_W x N_W integer multiplier, three register stages.
//   Stage 1: radix-4 Booth recoding of b and partial-product generation.
//   Stage 2: carry-save compression of the partial products into sum/carry rows.
//   Stage 3: final carry-propagate add into out.
// Parameters:
//   UNSIGNED  1 = unsigned operands/product, 0 = two's-complement signed
//   M_W       width of a (>=2)
//   N_W       width of b (>=2)
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, clears every pipeline register
//   a    multiplicand, M_W bits
//   b    multiplier, N_W bits
//   out  registered product a*b, M_W+N_W bits, valid 3 edges after sampling
module optmult #(
  parameter int unsigned UNSIGNED = 1,
  parameter int unsigned M_W      = 8,
  parameter int unsigned N_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [M_W-1:0]       a,
  input  logic [N_W-1:0]       b,
  output logic [M_W+N_W-1:0]   out
);

  localparam int unsigned P  = M_W + N_W;
  // b is extended by one or two bits to an even width so that the top Booth
  // digit always sees the true sign (or a zero) of b in both modes.
  localparam int unsigned BW = ((N_W + 2) / 2) * 2;
  localparam int unsigned ND = BW / 2;
  localparam logic [P-1:0] ONE = P'(1);

  logic          fill_a;
  logic          fill_b;
  logic [P-1:0]  a_ext;
  logic [BW-1:0] b_ext;
  logic [BW:0]   b_pad;

  assign fill_a = (UNSIGNED == 0) ? a[M_W-1] : 1'b0;
  assign fill_b = (UNSIGNED == 0) ? b[N_W-1] : 1'b0;
  assign a_ext  = {{N_W{fill_a}}, a};
  assign b_ext  = {{(BW-N_W){fill_b}}, b};
  assign b_pad  = {b_ext, 1'b0};

  // Stage 1: Booth digits in {-2,-1,0,+1,+2}; every row is kept at full
  // product width, so negation and shifting are exact modulo 2^P.
  logic [P-1:0] pp_d [ND];
  logic [P-1:0] pp_q [ND];

  always_comb begin
    logic [2:0]   sel;
    logic [P-1:0] mag;
    logic         neg;
    logic [P-1:0] row;
    sel = '0;
    mag = '0;
    neg = 1'b0;
    row = '0;
    for (int unsigned i = 0; i < ND; i++) begin
      sel = b_pad[2*i +: 3];
      mag = '0;
      neg = 1'b0;
      case (sel)
        3'b001, 3'b010: mag = a_ext;
        3'b011:         mag = a_ext << 1;
        3'b100: begin
          mag = a_ext << 1;
          neg = 1'b1;
        end
        3'b101, 3'b110: begin
          mag = a_ext;
          neg = 1'b1;
        end
        default:        mag = '0;
      endcase
      row     = neg ? (~mag + ONE) : mag;
      pp_d[i] = row << (2*i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ND; i++) pp_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < ND; i++) pp_q[i] <= pp_d[i];
    end
  end

  // Stage 2: 3:2 carry-save array folding each row into the running
  // sum/carry pair; carries shifted out of the top bit are modulo 2^P.
  logic [P-1:0] sum_d;
  logic [P-1:0] carry_d;
  logic [P-1:0] sum_q;
  logic [P-1:0] carry_q;

  always_comb begin
    logic [P-1:0] s;
    logic [P-1:0] c;
    s = pp_q[0];
    c = pp_q[1];
    for (int unsigned i = 2; i < ND; i++) begin
      sum_d   = s ^ c ^ pp_q[i];
      carry_d = ((s & c) | (s & pp_q[i]) | (c & pp_q[i])) << 1;
      s       = sum_d;
      c       = carry_d;
    end
    sum_d   = s;
    carry_d = c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= '0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  // Stage 3: carry-propagate add.
  always_ff @(posedge clk) begin
    if (rst) out <= '0;
    else     out <= sum_q + carry_q;
  end

endmodule

// File: tb/tb_optmult.sv
// Testbench for optmult: four instances (8x8 unsigned/signed, 12x5
// unsigned/signed) checked against an arithmetic reference model that
// delays each product by the specified latency and discards it on reset.
module tb_optmult;

  logic        clk;
  logic        rst;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic [11:0] a12;
  logic [4:0]  b5;
  logic [15:0] out_u8;
  logic [15:0] out_s8;
  logic [16:0] out_u12;
  logic [16:0] out_s12;

  int checks = 0;
  int errors = 0;

  optmult #(.UNSIGNED(1), .M_W(8), .N_W(8)) u_u8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .out(out_u8));
  optmult #(.UNSIGNED(0), .M_W(8), .N_W(8)) u_s8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .out(out_s8));
  optmult #(.UNSIGNED(1), .M_W(12), .N_W(5)) u_u12 (
    .clk(clk), .rst(rst), .a(a12), .b(b5), .out(out_u12));
  optmult #(.UNSIGNED(0), .M_W(12), .N_W(5)) u_s12 (
    .clk(clk), .rst(rst), .a(a12), .b(b5), .out(out_s12));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact product of the operand values, reduced to mw+nw bits.
  function automatic longint ref_prod(longint x, longint y, int mw, int nw, bit uns);
    longint xv, yv, mask;
    if (uns) begin
      xv = x & ((longint'(1) << mw) - 1);
      yv = y & ((longint'(1) << nw) - 1);
    end else begin
      xv = (x <<< (64 - mw)) >>> (64 - mw);
      yv = (y <<< (64 - nw)) >>> (64 - nw);
    end
    mask = (longint'(1) << (mw + nw)) - 1;
    return (xv * yv) & mask;
  endfunction

  // Delay line of products; any reset edge empties it.
  bit     v_hist [3];
  longint e_hist [4][3];

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) v_hist[k] = 1'b0;
    end else begin
      v_hist[2] = v_hist[1];
      v_hist[1] = v_hist[0];
      v_hist[0] = 1'b1;
      for (int d = 0; d < 4; d++) begin
        e_hist[d][2] = e_hist[d][1];
        e_hist[d][1] = e_hist[d][0];
      end
      e_hist[0][0] = ref_prod(longint'(a8), longint'(b8), 8, 8, 1'b1);
      e_hist[1][0] = ref_prod(longint'(a8), longint'(b8), 8, 8, 1'b0);
      e_hist[2][0] = ref_prod(longint'(a12), longint'(b5), 12, 5, 1'b1);
      e_hist[3][0] = ref_prod(longint'(a12), longint'(b5), 12, 5, 1'b0);
    end
  end

  function automatic longint model_exp(int d);
    return v_hist[2] ? e_hist[d][2] : 64'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; a8 = '0; b8 = '0; a12 = '0; b5 = '0;
    step();
    step();
    checks++; if (out_u8 !== 16'd0) begin errors++; $display("FAIL reset_u8: got %0d expected 0", out_u8); end
    checks++; if (out_s8 !== 16'd0) begin errors++; $display("FAIL reset_s8: got %0d expected 0", out_s8); end
    checks++; if (out_u12 !== 17'd0) begin errors++; $display("FAIL reset_u12: got %0d expected 0", out_u12); end
    checks++; if (out_s12 !== 17'd0) begin errors++; $display("FAIL reset_s12: got %0d expected 0", out_s12); end
    rst = 1'b0; a8 = 8'd7; b8 = 8'd9; a12 = 12'd100; b5 = 5'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      a8 = '0; b8 = '0; a12 = '0; b5 = '0;
      checks++;
      if (out_u8 !== ((i == 2) ? 16'd63 : 16'd0)) begin
        errors++; $display("FAIL post_reset_u8[%0d]: got %0d expected %0d", i, out_u8, (i == 2) ? 63 : 0);
      end
      checks++;
      if (out_s12 !== ((i == 2) ? 17'd300 : 17'd0)) begin
        errors++; $display("FAIL post_reset_s12[%0d]: got %0d expected %0d", i, out_s12, (i == 2) ? 300 : 0);
      end
    end
  endtask

  task automatic test_latency();
    logic [7:0]  sa [5] = '{8'd3, 8'd7, 8'd0, 8'd0, 8'd0};
    logic [7:0]  sb [5] = '{8'd5, 8'd9, 8'd0, 8'd0, 8'd0};
    logic [15:0] ex [3] = '{16'd15, 16'd63, 16'd0};
    for (int i = 0; i < 5; i++) begin
      a8 = sa[i]; b8 = sb[i];
      step();
      if (i >= 2) begin
        checks++;
        if (out_u8 !== ex[i-2]) begin errors++; $display("FAIL latency_u8[%0d]: got %0d expected %0d", i, out_u8, ex[i-2]); end
        checks++;
        if (out_s8 !== ex[i-2]) begin errors++; $display("FAIL latency_s8[%0d]: got %0d expected %0d", i, out_s8, ex[i-2]); end
      end
    end
  endtask

  task automatic test_corners();
    logic [7:0]  sa [4] = '{8'h80, 8'h80, 8'hFF, 8'h7F};
    logic [7:0]  sb [4] = '{8'h80, 8'h7F, 8'hFF, 8'hFF};
    logic [15:0] eu [4] = '{16'd16384, 16'd16256, 16'd65025, 16'd32385};
    logic [15:0] es [4] = '{16'd16384, 16'hC080, 16'd1, 16'hFF81};
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin a8 = sa[i]; b8 = sb[i]; end
      else begin a8 = '0; b8 = '0; end
      step();
      if (i >= 2) begin
        checks++;
        if (out_u8 !== eu[i-2]) begin errors++; $display("FAIL corner_u8[%0d]: got %0d expected %0d", i-2, out_u8, eu[i-2]); end
        checks++;
        if (out_s8 !== es[i-2]) begin errors++; $display("FAIL corner_s8[%0d]: got %h expected %h", i-2, out_s8, es[i-2]); end
      end
    end
  endtask

  task automatic test_sweep();
    longint eu, es;
    for (int i = 0; i < 65536 + 2; i++) begin
      if (i < 65536) begin a8 = i[15:8]; b8 = i[7:0]; end
      else begin a8 = '0; b8 = '0; end
      step();
      eu = model_exp(0);
      es = model_exp(1);
      checks++;
      if (out_u8 !== eu[15:0]) begin errors++; $display("FAIL sweep_u8[%0d]: got %0d expected %0d", i, out_u8, eu[15:0]); end
      checks++;
      if (out_s8 !== es[15:0]) begin errors++; $display("FAIL sweep_s8[%0d]: got %0d expected %0d", i, out_s8, es[15:0]); end
    end
  endtask

  task automatic test_mid_reset();
    a8 = 8'd200; b8 = 8'd200;
    step(); step(); step();
    checks++;
    if (out_u8 !== 16'd40000) begin errors++; $display("FAIL midrst_full: got %0d expected 40000", out_u8); end
    rst = 1'b1;
    step();
    checks++; if (out_u8 !== 16'd0) begin errors++; $display("FAIL midrst_clear_u8: got %0d expected 0", out_u8); end
    checks++; if (out_s8 !== 16'd0) begin errors++; $display("FAIL midrst_clear_s8: got %0d expected 0", out_s8); end
    rst = 1'b0; a8 = 8'd3; b8 = 8'd3;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_u8 !== ((i >= 2) ? 16'd9 : 16'd0)) begin
        errors++; $display("FAIL midrst_after[%0d]: got %0d expected %0d", i, out_u8, (i >= 2) ? 9 : 0);
      end
    end
  endtask

  task automatic test_asym();
    logic [11:0] sa [4] = '{12'd4095, 12'd2048, 12'd2047, 12'd2048};
    logic [4:0]  sb [4] = '{5'd31, 5'd16, 5'd15, 5'd15};
    logic [16:0] eu [4] = '{17'd126945, 17'd32768, 17'd30705, 17'd30720};
    logic [16:0] es [4] = '{17'd1, 17'd32768, 17'd30705, 17'd100352};
    longint mu, ms;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin a12 = sa[i]; b5 = sb[i]; end
      else begin a12 = '0; b5 = '0; end
      step();
      if (i >= 2) begin
        checks++;
        if (out_u12 !== eu[i-2]) begin errors++; $display("FAIL asym_u[%0d]: got %0d expected %0d", i-2, out_u12, eu[i-2]); end
        checks++;
        if (out_s12 !== es[i-2]) begin errors++; $display("FAIL asym_s[%0d]: got %0d expected %0d", i-2, out_s12, es[i-2]); end
      end
    end
    for (int i = 0; i < 400; i++) begin
      a12 = 12'($urandom);
      b5  = 5'($urandom);
      step();
      mu = model_exp(2);
      ms = model_exp(3);
      checks++;
      if (out_u12 !== mu[16:0]) begin errors++; $display("FAIL asym_rand_u[%0d]: got %0d expected %0d", i, out_u12, mu[16:0]); end
      checks++;
      if (out_s12 !== ms[16:0]) begin errors++; $display("FAIL asym_rand_s[%0d]: got %0d expected %0d", i, out_s12, ms[16:0]); end
    end
  endtask

  task automatic test_back_to_back();
    longint eu, es;
    for (int i = 0; i < 300; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      rst = ($urandom_range(0, 39) == 0);
      step();
      eu = model_exp(0);
      es = model_exp(1);
      checks++;
      if (out_u8 !== eu[15:0]) begin errors++; $display("FAIL b2b_u8[%0d]: got %0d expected %0d", i, out_u8, eu[15:0]); end
      checks++;
      if (out_s8 !== es[15:0]) begin errors++; $display("FAIL b2b_s8[%0d]: got %0d expected %0d", i, out_s8, es[15:0]); end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; a8 = '0; b8 = '0; a12 = '0; b5 = '0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_corners();
    test_mid_reset();
    test_asym();
    test_back_to_back();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
